// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the signed up/down counter.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Masks step to its declared width and zero-extends it into a wide signed word
  function automatic logic signed [33:0] sext_step(
    input logic [31:0] step,
    input int unsigned width
  );
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return $signed({2'b00, step & mask});
  endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count calculation with limit wrap/saturate.
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 3
) (
  input  logic signed [WIDTH-1:0]  count,
  input  logic        [STEP_W-1:0] step,
  input  logic                     up_dn,
  input  logic                     sat_mode,
  input  logic signed [WIDTH-1:0]  lim_hi,
  input  logic signed [WIDTH-1:0]  lim_lo,
  output logic signed [WIDTH-1:0]  nxt,
  output logic                     ovf_nxt,
  output logic                     unf_nxt
);

  localparam int XW = WIDTH + 2;

  logic signed [33:0]   step_w;
  logic signed [XW-1:0] cnt_x;
  logic signed [XW-1:0] hi_x;
  logic signed [XW-1:0] lo_x;
  logic signed [XW-1:0] stp_x;
  logic signed [XW-1:0] sum_x;
  logic                 unused_ok;

  assign step_w = sext_step(32'(step), STEP_W);
  assign stp_x  = step_w[XW-1:0];
  assign cnt_x  = XW'(count);
  assign hi_x   = XW'(lim_hi);
  assign lo_x   = XW'(lim_lo);

  // Two guard bits keep the raw sum exact before the limit test
  assign sum_x = (up_dn == CNT_UP) ? cnt_x + stp_x : cnt_x - stp_x;

  assign unused_ok = ^{step_w, sum_x};

  always_comb begin
    nxt     = sum_x[WIDTH-1:0];
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (up_dn == CNT_UP) begin
      if (sum_x > hi_x) begin
        ovf_nxt = 1'b1;
        nxt     = sat_mode ? lim_hi : lim_lo;
      end
    end else begin
      if (sum_x < lo_x) begin
        unf_nxt = 1'b1;
        nxt     = sat_mode ? lim_lo : lim_hi;
      end
    end
  end

endmodule

// File: rtl/signed_updown_counter.sv
// Signed up/down counter: programmable step, limits, wrap/saturate, load.
module signed_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 3,
  parameter int RESET_VAL = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     up_dn,
  input  logic        [STEP_W-1:0] step,
  input  logic                     sat_mode,
  input  logic signed [WIDTH-1:0]  lim_hi,
  input  logic signed [WIDTH-1:0]  lim_lo,
  input  logic                     load,
  input  logic signed [WIDTH-1:0]  load_val,
  output logic signed [WIDTH-1:0]  count,
  output logic                     ovf,
  output logic                     unf,
  output logic                     at_hi,
  output logic                     at_lo,
  output logic                     cfg_err
);

  logic signed [WIDTH-1:0] count_q;
  logic signed [WIDTH-1:0] count_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    unf_q;
  logic                    unf_d;
  logic signed [WIDTH-1:0] calc_nxt;
  logic                    calc_ovf;
  logic                    calc_unf;
  logic                    take;

  cnt_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_calc (
    .count    (count_q),
    .step     (step),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .lim_hi   (lim_hi),
    .lim_lo   (lim_lo),
    .nxt      (calc_nxt),
    .ovf_nxt  (calc_ovf),
    .unf_nxt  (calc_unf)
  );

  assign cfg_err = lim_lo > lim_hi;
  assign take    = en && (step != '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (cfg_err) begin
      count_d = count_q;
    end else if (take) begin
      count_d = calc_nxt;
      ovf_d   = calc_ovf;
      unf_d   = calc_unf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= WIDTH'(RESET_VAL);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign at_hi = count_q == lim_hi;
  assign at_lo = count_q == lim_lo;

endmodule

// File: tb/tb_signed_updown_counter.sv
// Scoreboard bench for signed_updown_counter (WIDTH=8, STEP_W=3).
module tb_signed_updown_counter;

  typedef struct packed {
    logic signed [7:0] cnt;
    logic              ovf;
    logic              unf;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic              up_dn;
  logic        [2:0] step;
  logic              sat_mode;
  logic signed [7:0] lim_hi;
  logic signed [7:0] lim_lo;
  logic              load;
  logic signed [7:0] load_val;
  logic signed [7:0] count;
  logic              ovf;
  logic              unf;
  logic              at_hi;
  logic              at_lo;
  logic              cfg_err;

  exp_t q[$];
  int   mc;
  int   nvec;
  int   nerr;

  signed_updown_counter #(
    .WIDTH     (8),
    .STEP_W    (3),
    .RESET_VAL (0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up_dn    (up_dn),
    .step     (step),
    .sat_mode (sat_mode),
    .lim_hi   (lim_hi),
    .lim_lo   (lim_lo),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .at_hi    (at_hi),
    .at_lo    (at_lo),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: advance mc from current inputs, push expectation, clock
  task automatic tick();
    exp_t e;
    int   h;
    int   l;
    int   n;
    h     = lim_hi;
    l     = lim_lo;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (load) begin
      mc = load_val;
    end else if (l > h) begin
      mc = mc;
    end else if (en && step != 3'd0) begin
      n = up_dn ? mc + int'(step) : mc - int'(step);
      if (up_dn && n > h) begin
        e.ovf = 1'b1;
        mc    = sat_mode ? h : l;
      end else if (!up_dn && n < l) begin
        e.unf = 1'b1;
        mc    = sat_mode ? l : h;
      end else begin
        mc = n;
      end
    end
    e.cnt = 8'(mc);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input int lv, input logic e,
                       input logic u, input int s, input logic sat);
    load     = ld;
    load_val = 8'(lv);
    en       = e;
    up_dn    = u;
    step     = 3'(s);
    sat_mode = sat;
  endtask

  task automatic test_reset();
    exp_t e;
    nvec++;
    if (count !== 8'sd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_init: count=%0d ovf=%b unf=%b want 0 0 0",
               count, ovf, unf);
    end
    reset_n = 1'b1;
    #2;
    drive(1, 37, 0, 1, 0, 0);
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} || count !== 8'sd37) begin
      nerr++;
      $display("FAIL reset_load37: count=%0d want %0d", count, e.cnt);
    end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (count !== 8'sd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_async: count=%0d ovf=%b unf=%b want 0 0 0",
               count, ovf, unf);
    end
    mc = 0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_sat_up();
    exp_t e;
    int   want_c[3] = '{98, 100, 100};
    logic want_o[3] = '{1'b0, 1'b1, 1'b1};
    lim_hi = 8'sd100;
    lim_lo = -8'sd100;
    drive(1, 98, 0, 1, 3, 1);
    tick();
    drive(0, 0, 1, 1, 3, 1);
    q.pop_front();
    for (int i = 1; i < 3; i++) begin
      if (i > 0) tick();
      e = q.pop_front();
      nvec++;
      if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
          count !== 8'(want_c[i]) || ovf !== want_o[i] || at_hi !== 1'b1) begin
        nerr++;
        $display("FAIL sat_up[%0d]: count=%0d ovf=%b at_hi=%b want %0d %b 1",
                 i, count, ovf, at_hi, want_c[i], want_o[i]);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (ovf !== 1'b0 || count !== 8'sd0) begin
      nerr++;
      $display("FAIL sat_up_reset: count=%0d ovf=%b want 0 0", count, ovf);
    end
    mc = 0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    drive(1, 98, 0, 1, 3, 0);
    tick();
    q.pop_front();
    drive(0, 0, 1, 1, 3, 0);
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
        count !== -8'sd100 || ovf !== 1'b1 || at_lo !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_up: count=%0d ovf=%b at_lo=%b want -100 1 1",
               count, ovf, at_lo);
    end
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
        count !== -8'sd97 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_up_next: count=%0d ovf=%b want -97 0", count, ovf);
    end
  endtask

  task automatic test_down();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      drive(1, -99, 0, 0, 2, 1'(s));
      tick();
      q.pop_front();
      drive(0, 0, 1, 0, 2, 1'(s));
      tick();
      e = q.pop_front();
      nvec++;
      if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} || unf !== 1'b1 ||
          count !== (s == 1 ? -8'sd100 : 8'sd100)) begin
        nerr++;
        $display("FAIL down_sat%0d: count=%0d unf=%b want %0d 1",
                 s, count, unf, s == 1 ? -100 : 100);
      end
    end
  endtask

  task automatic test_full_range();
    exp_t e;
    lim_hi = 8'sd127;
    lim_lo = -8'sd128;
    for (int s = 0; s < 2; s++) begin
      drive(1, 126, 0, 1, 7, 1'(s));
      tick();
      q.pop_front();
      drive(0, 0, 1, 1, 7, 1'(s));
      tick();
      e = q.pop_front();
      nvec++;
      if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} || ovf !== 1'b1 ||
          count !== (s == 1 ? 8'sd127 : -8'sd128)) begin
        nerr++;
        $display("FAIL full_up_sat%0d: count=%0d ovf=%b want %0d 1",
                 s, count, ovf, s == 1 ? 127 : -128);
      end
    end
    drive(1, -127, 0, 0, 7, 1);
    tick();
    q.pop_front();
    drive(0, 0, 1, 0, 7, 1);
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
        count !== -8'sd128 || unf !== 1'b1) begin
      nerr++;
      $display("FAIL full_down: count=%0d unf=%b want -128 1", count, unf);
    end
  endtask

  task automatic test_cfg_err();
    exp_t e;
    lim_hi = 8'sd5;
    lim_lo = 8'sd10;
    drive(0, 0, 1, 1, 1, 0);
    #1;
    nvec++;
    if (cfg_err !== 1'b1) begin
      nerr++;
      $display("FAIL cfg_err_flag: cfg_err=%b want 1", cfg_err);
    end
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
        count !== -8'sd128 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL cfg_err_hold: count=%0d ovf=%b want -128 0", count, ovf);
    end
    drive(1, 50, 1, 1, 1, 0);
    tick();
    e = q.pop_front();
    nvec++;
    if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} || count !== 8'sd50) begin
      nerr++;
      $display("FAIL cfg_err_load: count=%0d want 50", count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   h;
    int   l;
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        h = $urandom_range(127, 0) - ($urandom_range(3, 0) == 0 ? 40 : 0);
        l = -int'($urandom_range(128, 0));
        if ($urandom_range(7, 0) == 0) l = h + 1 + int'($urandom_range(5, 0));
        if (l > 127) l = 127;
        lim_hi = 8'(h);
        lim_lo = 8'(l);
      end
      drive($urandom_range(9, 0) == 0, int'($urandom_range(255, 0)) - 128,
            $urandom_range(5, 0) != 0, 1'($urandom), int'($urandom_range(7, 0)),
            1'($urandom));
      tick();
      e = q.pop_front();
      nvec++;
      if ({count, ovf, unf} !== {e.cnt, e.ovf, e.unf} ||
          at_hi !== (count == lim_hi) || at_lo !== (e.cnt == lim_lo) ||
          cfg_err !== (lim_lo > lim_hi)) begin
        nerr++;
        $display("FAIL b2b[%0d]: count=%0d ovf=%b unf=%b hi=%b lo=%b err=%b want %0d %b %b",
                 i, count, ovf, unf, at_hi, at_lo, cfg_err, e.cnt, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    mc       = 0;
    reset_n  = 1'b0;
    lim_hi   = 8'sd100;
    lim_lo   = -8'sd100;
    drive(0, 0, 0, 1, 0, 0);
    #12;
    test_reset();
    test_sat_up();
    test_wrap_up();
    test_down();
    test_full_range();
    test_cfg_err();
    test_back_to_back();
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
